// File: rtl/fuzz_harness_pkg.sv
// Shared types and constants for the LFSR-stimulus / MISR-signature fuzz harness.
// Holds the FSM encoding, default feedback masks and small elaboration helpers.
package fuzz_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Widest shift register the feedback helper accepts; narrower callers zero-extend.
  localparam int unsigned FB_MAX_W = 1024;

  localparam logic [255:0] DEF_TAPS =
    (256'd1 << 255) | (256'd1 << 253) | (256'd1 << 250) | (256'd1 << 245);

  localparam logic [191:0] DEF_MTAPS =
    (192'd1 << 191) | (192'd1 << 189) | (192'd1 << 180) | (192'd1 << 177);

  function automatic logic fb_bit(input logic [FB_MAX_W-1:0] state,
                                  input logic [FB_MAX_W-1:0] mask);
    return ^(state & mask);
  endfunction

  // Counter width for a limit, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/fuzz_stim_sig_harness_if.sv
// Bus between the fuzz harness and whoever drives/observes it.
// The harness side is the slave; the bench or wrapper side is the master.
interface fuzz_stim_sig_harness_if #(
  parameter int unsigned IN_W    = 256,
  parameter int unsigned OUT_W   = 192,
  parameter int unsigned NUM_VEC = 21
);
  localparam int unsigned VIDX_W = $clog2(NUM_VEC + 1);

  logic              start;
  logic [IN_W-1:0]   seed;
  logic [OUT_W-1:0]  exp_sig;
  logic [IN_W-1:0]   stim;
  logic [OUT_W-1:0]  y;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  sig;
  logic              match;
  logic [VIDX_W-1:0] vec_idx;

  modport master (
    output start, seed, exp_sig, y,
    input  stim, busy, done, sig, match, vec_idx
  );

  modport slave (
    input  start, seed, exp_sig, y,
    output stim, busy, done, sig, match, vec_idx
  );
endinterface

// File: rtl/fuzz_lfsr_step.sv
// One Fibonacci-style shift step: shift left, feed parity of (state & MASK) into bit 0.
// Shared by the stimulus LFSR and the MISR core.
module fuzz_lfsr_step
  import fuzz_harness_pkg::*;
#(
  parameter int unsigned     W    = 8,
  parameter logic [W-1:0]    MASK = '1
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  assign nxt = {cur[W-2:0], fb_bit(FB_MAX_W'(cur), FB_MAX_W'(MASK))};

endmodule

// File: rtl/fuzz_stim_sig_harness.sv
// Streams NUM_VEC LFSR vectors (leading all-zero vector) onto stim and compacts the
// DUT response y into a MISR signature, flagging match against exp_sig at the end.
module fuzz_stim_sig_harness
  import fuzz_harness_pkg::*;
#(
  parameter int unsigned      IN_W    = 256,
  parameter int unsigned      OUT_W   = 192,
  parameter int unsigned      NUM_VEC = 21,
  parameter int unsigned      HOLD    = 1,
  parameter int unsigned      LAT     = 0,
  parameter logic [IN_W-1:0]  TAPS    = DEF_TAPS[IN_W-1:0],
  parameter logic [OUT_W-1:0] MTAPS   = DEF_MTAPS[OUT_W-1:0]
) (
  input  logic                  clk,
  input  logic                  rst,
  fuzz_stim_sig_harness_if.slave bus
);

  localparam int unsigned VIDX_W = $clog2(NUM_VEC + 1);
  localparam int unsigned HCNT_W = cnt_w(HOLD);
  localparam int unsigned DCNT_W = cnt_w(LAT);

  localparam logic [VIDX_W-1:0] LAST_VEC   = VIDX_W'(NUM_VEC - 1);
  localparam logic [HCNT_W-1:0] LAST_HOLD  = HCNT_W'(HOLD - 1);
  localparam logic [DCNT_W-1:0] LAST_DRAIN = DCNT_W'((LAT > 0) ? (LAT - 1) : 0);

  state_t state;
  state_t state_nxt;

  logic [IN_W-1:0]   stim_q;
  logic [IN_W-1:0]   lfsr_q;
  logic [IN_W-1:0]   lfsr_nxt;
  logic [OUT_W-1:0]  sig_q;
  logic [OUT_W-1:0]  misr_nxt;
  logic              busy_q;
  logic              match_q;
  logic [VIDX_W-1:0] vec_idx_q;
  logic [HCNT_W-1:0] hold_cnt;
  logic [DCNT_W-1:0] drain_cnt;

  logic accept;
  logic window_end;
  logic last_vec;
  logic advance;
  logic drain_end;
  logic is_done;
  logic sample_en;
  logic sample_dly;

  fuzz_lfsr_step #(.W(IN_W), .MASK(TAPS)) u_stim_lfsr (
    .cur (lfsr_q),
    .nxt (lfsr_nxt)
  );

  fuzz_lfsr_step #(.W(OUT_W), .MASK(MTAPS)) u_misr_core (
    .cur (sig_q),
    .nxt (misr_nxt)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is only ever updated with non-blocking assignments.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_RUN;
      ST_RUN:   if (window_end && last_vec) state_nxt = (LAT == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (drain_end) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == ST_IDLE) && bus.start;
    window_end = (state == ST_RUN) && (hold_cnt == LAST_HOLD);
    last_vec   = (vec_idx_q == LAST_VEC);
    advance    = window_end && !last_vec;
    drain_end  = (state == ST_DRAIN) && (drain_cnt == LAST_DRAIN);
    is_done    = (state == ST_DONE);
    sample_en  = window_end;
  end

  // The response to a vector appears LAT cycles after its last hold cycle.
  generate
    if (LAT == 0) begin : g_no_lat
      assign sample_dly = sample_en;
    end else begin : g_lat
      logic [LAT-1:0] sample_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sample_pipe <= '0;
        else     sample_pipe <= (sample_pipe << 1) | LAT'(sample_en);
      end
      assign sample_dly = sample_pipe[LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: no memories here, so every register takes an async reset value.
    if (rst) begin
      stim_q    <= '0;
      lfsr_q    <= '0;
      sig_q     <= '0;
      busy_q    <= 1'b0;
      match_q   <= 1'b0;
      vec_idx_q <= '0;
      hold_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        stim_q    <= '0;
        vec_idx_q <= '0;
        lfsr_q    <= (bus.seed == '0) ? IN_W'(1) : bus.seed;
      end else if (advance) begin
        vec_idx_q <= vec_idx_q + 1'b1;
        // Vector 1 is the seed itself; later vectors step the LFSR first.
        if (vec_idx_q == '0) begin
          stim_q <= lfsr_q;
        end else begin
          stim_q <= lfsr_nxt;
          lfsr_q <= lfsr_nxt;
        end
      end

      if (state == ST_RUN)   hold_cnt  <= window_end ? '0 : hold_cnt + 1'b1;
      if (state == ST_DRAIN) drain_cnt <= drain_end ? '0 : drain_cnt + 1'b1;

      if (accept)          sig_q <= '0;
      else if (sample_dly) sig_q <= misr_nxt ^ bus.y;

      if (accept)       match_q <= 1'b0;
      else if (is_done) match_q <= (sig_q == bus.exp_sig);

      if (accept)       busy_q <= 1'b1;
      else if (is_done) busy_q <= 1'b0;
    end
  end

  assign bus.stim    = stim_q;
  assign bus.busy    = busy_q;
  assign bus.done    = is_done;
  assign bus.sig     = sig_q;
  assign bus.match   = match_q;
  assign bus.vec_idx = vec_idx_q;

endmodule
